// File: rtl/vr_pkg.sv
// Shared types and constants for the VR word-transfer responder.
package vr_pkg;

    localparam int VR_DROP_LAT = 2;
    localparam int VR_CNT_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACK      = 3'd1,
        S_DROP1    = 3'd2,
        S_DROP2    = 3'd3,
        S_WAIT_LOW = 3'd4
    } vr_resp_state_t;

endpackage

// File: rtl/vr_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy output.
module vr_sync_fifo #(
    parameter int DATA  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA-1:0]              push_data,
    input  logic                         pop,
    output logic [DATA-1:0]              head,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Storage is not reset, so the head is forced to zero while empty.
    assign head  = empty ? '0 : mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/vr_responder.sv
// VR protocol responder: acknowledges words with a one-cycle ready pulse,
// checks the initiator's valid drop timing and buffers words downstream.
module vr_responder
    import vr_pkg::*;
#(
    parameter int DATA  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid,
    input  logic [DATA-1:0]              data,
    output logic                         ready,
    output logic                         out_valid,
    output logic [DATA-1:0]              out_data,
    input  logic                         out_ready,
    input  logic                         err_clr,
    output logic                         proto_err,
    output logic [VR_CNT_W-1:0]          word_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [2:0]                   fsm_state
);

    vr_resp_state_t       state;
    vr_resp_state_t       next_state;
    logic                 ready_q;
    logic                 err_q;
    logic                 set_err;
    logic [VR_CNT_W-1:0]  cnt_q;
    logic                 push;
    logic                 fifo_empty;
    logic                 fifo_full;

    // Only the FSM pushes, so the space reserved in IDLE is still free in ACK.
    assign push = (state == S_ACK);

    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid && !fifo_full) next_state = S_ACK;
            end
            S_ACK: begin
                next_state = S_DROP1;
            end
            S_DROP1: begin
                if (!valid) set_err = 1'b1;
                next_state = S_DROP2;
            end
            S_DROP2: begin
                if (valid) begin
                    set_err    = 1'b1;
                    next_state = S_WAIT_LOW;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_WAIT_LOW: begin
                if (!valid) next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == S_ACK);
            // Set has priority over clear.
            if (set_err)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
            if (push) cnt_q <= cnt_q + 1'b1;
        end
    end

    vr_sync_fifo #(
        .DATA  (DATA),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (data),
        .pop       (out_ready),
        .head      (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    assign ready     = ready_q;
    assign out_valid = !fifo_empty;
    assign proto_err = err_q;
    assign word_cnt  = cnt_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_vr_responder.sv
// Directed bench for vr_responder: a queue-based model checked every cycle
// plus hand-computed expectations per scenario.
module tb_vr_responder;
    import vr_pkg::*;

    localparam int DATA  = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            valid = 1'b0;
    logic [DATA-1:0] data = '0;
    logic            out_ready = 1'b0;
    logic            err_clr = 1'b0;
    logic            ready;
    logic            out_valid;
    logic [DATA-1:0] out_data;
    logic            proto_err;
    logic [15:0]     word_cnt;
    logic [LW-1:0]   level;
    logic [2:0]      fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vr_responder #(.DATA(DATA), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .data      (data),
        .ready     (ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .proto_err (proto_err),
        .word_cnt  (word_cnt),
        .level     (level),
        .fsm_state (fsm_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ack_age: edges since ready rose (-1 = no transfer in flight).
    logic [DATA-1:0] exp_q[$];
    int              ack_age = -1;
    bit              hold_low = 0;
    logic [15:0]     m_cnt = '0;
    bit              m_err = 0;
    bit              chk_en = 0;

    always @(posedge clk) begin : model
        bit se;
        bit push_now;
        bit do_pop;
        int sz;
        se = 0;
        push_now = 0;
        if (reset) begin
            exp_q.delete();
            ack_age  = -1;
            hold_low = 0;
            m_cnt    = '0;
            m_err    = 0;
        end else begin
            sz     = exp_q.size();
            do_pop = (sz > 0) && out_ready;
            if (hold_low) begin
                if (!valid) hold_low = 0;
            end else if (ack_age < 0) begin
                if (valid && sz < DEPTH) ack_age = 0;
            end else if (ack_age == 0) begin
                push_now = 1;
                ack_age  = 1;
            end else if (ack_age < VR_DROP_LAT) begin
                if (!valid) se = 1;
                ack_age = ack_age + 1;
            end else begin
                if (valid) begin
                    se = 1;
                    hold_low = 1;
                end
                ack_age = -1;
            end
            if (do_pop) void'(exp_q.pop_front());
            if (push_now) begin
                exp_q.push_back(data);
                m_cnt = m_cnt + 16'd1;
            end
            m_err = se ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("ready", 32'(ready), 32'(ack_age == 0));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
            check("level", 32'(level), exp_q.size());
            check("word_cnt", 32'(word_cnt), 32'(m_cnt));
            check("proto_err", 32'(proto_err), 32'(m_err));
        end
    end

    // Words leaving the downstream port, recorded the cycle before the pop edge.
    logic [DATA-1:0] got_q[$];
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready === 1'b1) break;
        end
        check("wait_ready", 32'(ready), 32'h1);
    endtask

    task automatic send(input logic [31:0] d);
        valid = 1'b1;
        data  = d;
        wait_ready();
        tick();
        tick();
        valid = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        reset = 1'b1;
        repeat (2) tick();
        chk_en = 1;
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_word_cnt", 32'(word_cnt), 32'h0);
        check("rst_proto_err", 32'(proto_err), 32'h0);
        reset = 1'b0;
        tick();

        // Single compliant transfer
        out_ready = 1'b1;
        valid = 1'b1;
        data  = 32'hDEADBEEF;
        tick();
        check("single_ready", 32'(ready), 32'h1);
        tick();
        check("single_ready_low", 32'(ready), 32'h0);
        check("single_out_valid", 32'(out_valid), 32'h1);
        check("single_out_data", out_data, 32'hDEADBEEF);
        check("single_word_cnt", 32'(word_cnt), 32'h1);
        tick();
        valid = 1'b0;
        tick();
        check("single_proto_err", 32'(proto_err), 32'h0);
        check("single_idle", 32'(fsm_state), 32'(S_IDLE));

        // Back-pressure: four words fill the FIFO, the fifth stalls
        out_ready = 1'b0;
        repeat (2) tick();
        got_q.delete();
        for (int w = 1; w <= 4; w++) send(32'(w));
        check("bp_level_full", 32'(level), 32'h4);
        check("bp_head", out_data, 32'h1);
        valid = 1'b1;
        data  = 32'h5;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_stall_ready", 32'(ready), 32'h0);
        end
        out_ready = 1'b1;
        wait_ready();
        tick();
        tick();
        valid = 1'b0;
        tick();
        repeat (8) tick();
        check("bp_count", got_q.size(), 32'h5);
        for (int i = 0; i < got_q.size() && i < 5; i++) check("bp_order", got_q[i], 32'(i + 1));
        check("bp_word_cnt", 32'(word_cnt), 32'h6);

        // Late drop: valid held past DROP2
        valid = 1'b1;
        data  = 32'hA5A5A5A5;
        wait_ready();
        tick();
        tick();
        check("late_no_err_yet", 32'(proto_err), 32'h0);
        tick();
        check("late_err", 32'(proto_err), 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("late_hold_ready", 32'(ready), 32'h0);
            check("late_wait_low", 32'(fsm_state), 32'(S_WAIT_LOW));
        end
        valid = 1'b0;
        tick();
        check("late_back_idle", 32'(fsm_state), 32'(S_IDLE));
        check("late_err_sticky", 32'(proto_err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("late_err_cleared", 32'(proto_err), 32'h0);
        tick();

        // Early drop: valid falls one cycle after ready
        out_ready = 1'b0;
        valid = 1'b1;
        data  = 32'h00001234;
        wait_ready();
        tick();
        valid = 1'b0;
        tick();
        check("early_err", 32'(proto_err), 32'h1);
        tick();
        check("early_idle", 32'(fsm_state), 32'(S_IDLE));
        check("early_out_valid", 32'(out_valid), 32'h1);
        check("early_out_data", out_data, 32'h00001234);
        out_ready = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check("early_drained", 32'(out_valid), 32'h0);

        // Reset mid-transfer with two words buffered
        out_ready = 1'b0;
        send(32'h11);
        send(32'h22);
        check("rm_level2", 32'(level), 32'h2);
        valid = 1'b1;
        data  = 32'h33;
        wait_ready();
        tick();
        check("rm_in_drop1", 32'(fsm_state), 32'(S_DROP1));
        check("rm_level3", 32'(level), 32'h3);
        reset = 1'b1;
        tick();
        check("rm_level0", 32'(level), 32'h0);
        check("rm_out_valid", 32'(out_valid), 32'h0);
        check("rm_word_cnt", 32'(word_cnt), 32'h0);
        reset = 1'b0;
        tick();
        check("rm_reack", 32'(ready), 32'h1);
        tick();
        tick();
        valid = 1'b0;
        tick();
        check("rm_word_cnt1", 32'(word_cnt), 32'h1);
        out_ready = 1'b1;
        repeat (3) tick();

        // Counter wrap from 0xFFFF
        force dut.cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.cnt_q;
        tick();
        check("wrap_pre", 32'(word_cnt), 32'hFFFF);
        send(32'hCAFEF00D);
        check("wrap", 32'(word_cnt), 32'h0);
        repeat (3) tick();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
